pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_pkg.sv | 8 +
 rtl/pulse_stretch_cycle_timer.sv | 19 +
 rtl/pulse_stretch.sv | 86 ++++++++
 tb/tb_pulse_stretch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state encoding and default timing constants for pulse_stretch.
package pulse_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
    localparam int DEF_HIGH_CYCLES = 50;
    localparam int DEF_GAP_CYCLES = 10;
    localparam int DEF_QUEUE_DEPTH = 3;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pulse_stretch_cycle_timer.sv
// cycle_timer: loadable down-counter that holds at zero and flags when it gets there.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign zero = cnt == '0;
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches a one-cycle blip into an exact HIGH/GAP pulse.
// Define PULSE_QUEUE_EN to hold busy triggers in a saturating pending count instead of dropping them.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic blip,
    output logic out,
    output logic busy,
    output logic dropped
);
    localparam logic [CNT_W-1:0] HIGH_VAL = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_VAL = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t state, next;
    logic load, zero, pend, full;
    logic [CNT_W-1:0] load_val;

    cycle_timer #(.W(CNT_W)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .load(load),
        .value(load_val),
        .zero(zero)
    );

    assign busy = state != IDLE;

    // pend: another pulse should follow immediately when the current segment ends
    always_comb begin
        next = state;
        load = 1'b0;
        load_val = HIGH_VAL;
        case (state)
            IDLE: if (blip) begin
                next = HIGH;
                load = 1'b1;
            end
            HIGH: if (zero) begin
                next = GAP_CYCLES > 0 ? GAP : (pend ? HIGH : IDLE);
                load = GAP_CYCLES > 0 || pend;
                load_val = GAP_CYCLES > 0 ? GAP_VAL : HIGH_VAL;
            end
            GAP: if (zero) begin
                next = pend ? HIGH : IDLE;
                load = pend;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            out <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state <= next;
            out <= next == HIGH;
            dropped <= blip && busy && full;
        end

`ifdef PULSE_QUEUE_EN
    localparam int QW = $clog2(QUEUE_DEPTH + 1);
    logic [QW-1:0] count;
    logic inc, take;
    assign full = count == QW'(QUEUE_DEPTH);
    // a blip in the last busy cycle is queued and served in the same edge
    assign pend = count != '0 || blip;
    assign inc = blip && busy && !full;
    assign take = busy && load && next == HIGH;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count <= '0;
        else count <= count + QW'(inc) - QW'(take);
`else
    assign full = 1'b1;
    assign pend = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed and random stimulus checked each cycle against a pulse-interval model.
module tb_pulse_stretch;
    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 3;
    localparam int NONE = -1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic blip = 1'b0;
    logic out, busy, dropped;
    logic out0, busy0, dropped0;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int start = NONE;
    int pending = 0;
    logic m_out, m_busy, m_drop;
    int out_cnt, busy_cnt, drop_cnt, m_out_cnt, m_drop_cnt;
    int out0_cnt, drop0_cnt, out0_run, out0_max;

    pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8), .QUEUE_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .blip(blip), .out(out), .busy(busy), .dropped(dropped)
    );

    pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(0), .CNT_W(8), .QUEUE_DEPTH(D)) dut0 (
        .clk(clk), .reset_n(reset_n), .blip(blip), .out(out0), .busy(busy0), .dropped(dropped0)
    );

    always #5 clk = ~clk;

    // a pulse started at edge s is busy after edges s .. s+H+G-1
    function automatic logic in_busy(input int k);
        return k >= start && k <= start + H + G - 1;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear();
        out_cnt = 0; busy_cnt = 0; drop_cnt = 0; m_out_cnt = 0; m_drop_cnt = 0;
        out0_cnt = 0; drop0_cnt = 0; out0_run = 0; out0_max = 0;
    endtask

    task automatic step(input logic b, input logic r);
        logic bp;
        @(negedge clk);
        blip = b;
        reset_n = r;
        if (!r) begin
            #1;
            check_bit("async_reset_out", out, 1'b0);
            check_bit("async_reset_busy", busy, 1'b0);
        end
        @(posedge clk);
        n++;
        m_drop = 1'b0;
        if (!r) begin
            start = NONE;
            pending = 0;
        end else begin
            bp = in_busy(n - 1);
            if (!bp) begin
                if (b) start = n;
            end else begin
`ifdef PULSE_QUEUE_EN
                if (b) begin
                    if (pending == D) m_drop = 1'b1;
                    else pending++;
                end
                if (n == start + H + G && pending > 0) begin
                    pending--;
                    start = n;
                end
`else
                m_drop = b;
`endif
            end
        end
        m_out = n >= start && n <= start + H - 1;
        m_busy = in_busy(n);
        #1;
        check_bit("out", out, m_out);
        check_bit("busy", busy, m_busy);
        check_bit("dropped", dropped, m_drop);
        out_cnt += int'(out);
        busy_cnt += int'(busy);
        drop_cnt += int'(dropped);
        m_out_cnt += int'(m_out);
        m_drop_cnt += int'(m_drop);
        out0_cnt += int'(out0);
        drop0_cnt += int'(dropped0);
        out0_run = out0 ? out0_run + 1 : 0;
        if (out0_run > out0_max) out0_max = out0_run;
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0);
        check_bit("reset_dropped", dropped, 1'b0);
        repeat (2) step(1'b0, 1'b1);

        clear();
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        check_int("single_out_len", out_cnt, 4);
        check_int("single_busy_len", busy_cnt, 6);
        check_int("model_single_out_len", m_out_cnt, 4);

        clear();
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (15) step(1'b0, 1'b1);
`ifdef PULSE_QUEUE_EN
        check_int("two_blip_out_len", out_cnt, 8);
        check_int("two_blip_drops", drop_cnt, 0);
        check_int("model_two_blip_out_len", m_out_cnt, 8);
        check_int("gap0_run", out0_max, 8);
`else
        check_int("two_blip_out_len", out_cnt, 4);
        check_int("two_blip_drops", drop_cnt, 1);
        check_int("model_two_blip_drops", m_drop_cnt, 1);
        check_int("gap0_run", out0_max, 4);
        check_int("gap0_drops", drop0_cnt, 1);
`endif

        clear();
        repeat (6) step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1);
`ifdef PULSE_QUEUE_EN
        check_int("burst_out_len", out_cnt, 16);
        check_int("burst_drops", drop_cnt, 2);
        check_int("model_burst_drops", m_drop_cnt, 2);
`else
        check_int("burst_out_len", out_cnt, 4);
        check_int("burst_drops", drop_cnt, 5);
        check_int("model_burst_drops", m_drop_cnt, 5);
`endif

        clear();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        check_int("reset_mid_pulse_out_len", out_cnt, 6);
        check_int("reset_mid_pulse_busy_len", busy_cnt, 8);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) == 0, $urandom_range(199) != 0);
        repeat (40) step(1'b0, 1'b1);
        check_bit("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
